// File: rtl/freelist_pkg.sv
// Shared rename constants and types for the physical-register free list.
// Sizes follow from the ROB depth; tags 0..N_ARCH_REG-1 start out architecturally mapped.
package freelist_pkg;

    localparam int N_ARCH_REG  = 32;
    localparam int ZERO_REG    = 31;
    localparam int N_ENTRY_ROB = 32;
    localparam int N_PHYS      = N_ENTRY_ROB + 33;
    localparam int DEPTH       = N_PHYS - 32;
    localparam int PR_TAG_W    = $clog2(N_PHYS);
    localparam int PTR_W       = $clog2(DEPTH);
    localparam int CNT_W       = $clog2(DEPTH + 1);

    typedef logic [PR_TAG_W-1:0] phys_tag_t;
    typedef logic [PTR_W-1:0]    fl_ptr_t;
    typedef logic [CNT_W-1:0]    fl_cnt_t;

    // Number of allocations between two pointers, modulo the non-power-of-two depth.
    function automatic fl_ptr_t ptr_dist(input fl_ptr_t from, input fl_ptr_t to);
        logic [PTR_W:0] d;
        if (to >= from)
            d = {1'b0, to} - {1'b0, from};
        else
            d = {1'b0, to} + (PTR_W+1)'(DEPTH) - {1'b0, from};
        return fl_ptr_t'(d);
    endfunction

endpackage

// File: rtl/freelist_if.sv
// Dispatch, retire and recovery signals between the rename stage and the free list.
interface freelist_if;
    import freelist_pkg::*;

    logic      fetch_PR_0;
    logic      fetch_PR_1;
    logic      is_0_br;
    logic      recovery_br;
    logic      rt_valid_0;
    logic      rt_valid_1;
    phys_tag_t Told_in_0;
    phys_tag_t Told_in_1;
    phys_tag_t freelist_0;
    phys_tag_t freelist_1;
    logic      pr_valid_0;
    logic      pr_valid_1;
    fl_cnt_t   fl_count;
    logic      fl_busy;

    modport master (
        output fetch_PR_0, fetch_PR_1, is_0_br, recovery_br,
        output rt_valid_0, rt_valid_1, Told_in_0, Told_in_1,
        input  freelist_0, freelist_1, pr_valid_0, pr_valid_1, fl_count, fl_busy
    );

    modport slave (
        input  fetch_PR_0, fetch_PR_1, is_0_br, recovery_br,
        input  rt_valid_0, rt_valid_1, Told_in_0, Told_in_1,
        output freelist_0, freelist_1, pr_valid_0, pr_valid_1, fl_count, fl_busy
    );

endinterface

// File: rtl/freelist_ptr_add.sv
// Circular pointer increment by 0..2 with an explicit wrap at DEPTH.
module fl_ptr_add
    import freelist_pkg::*;
(
    input  fl_ptr_t    ptr,
    input  logic [1:0] inc,
    output fl_ptr_t    sum
);

    logic [PTR_W:0] raw;

    // ptr < DEPTH and inc <= 2, so a single conditional subtract covers the wrap.
    always_comb begin
        raw = {1'b0, ptr} + (PTR_W+1)'(inc);
        if (raw >= (PTR_W+1)'(DEPTH))
            sum = fl_ptr_t'(raw - (PTR_W+1)'(DEPTH));
        else
            sum = fl_ptr_t'(raw);
    end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular FIFO of tags, allocated at head, returned at tail,
// with a single branch checkpoint of the allocation pointer for misprediction rollback.
module freelist
    import freelist_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    freelist_if.slave fl
);

    typedef logic [CNT_W:0] fl_sum_t;

    phys_tag_t  entry [DEPTH];
    fl_ptr_t    head;
    fl_ptr_t    tail;
    fl_ptr_t    ckpt_head;
    logic       ckpt_valid;
    fl_cnt_t    count;

    logic       grant_0;
    logic       grant_1;
    logic       ret_0;
    logic       ret_1;
    logic [1:0] n_grant;
    logic [1:0] n_ret;
    fl_ptr_t    head_p1;
    fl_ptr_t    head_adv;
    fl_ptr_t    tail_p1;
    fl_ptr_t    tail_adv;
    fl_ptr_t    rollback;
    fl_sum_t    count_sum;

    fl_ptr_add u_head_p1  (.ptr(head), .inc(2'd1),   .sum(head_p1));
    fl_ptr_add u_head_adv (.ptr(head), .inc(n_grant), .sum(head_adv));
    fl_ptr_add u_tail_p1  (.ptr(tail), .inc(2'd1),   .sum(tail_p1));
    fl_ptr_add u_tail_adv (.ptr(tail), .inc(n_ret),   .sum(tail_adv));

    // Grants are zero-latency; recovery kills dispatch but retire returns still count.
    always_comb begin
        grant_0 = fl.fetch_PR_0 && (count != '0) && !fl.recovery_br;
        grant_1 = fl.fetch_PR_1 && !fl.recovery_br &&
                  (grant_0 ? (count >= fl_cnt_t'(2)) : (count != '0));
        ret_0   = fl.rt_valid_0 && (fl.Told_in_0 != phys_tag_t'(ZERO_REG));
        ret_1   = fl.rt_valid_1 && (fl.Told_in_1 != phys_tag_t'(ZERO_REG));
        n_grant = {1'b0, grant_0} + {1'b0, grant_1};
        n_ret   = {1'b0, ret_0} + {1'b0, ret_1};

        rollback = '0;
        if (fl.recovery_br && ckpt_valid)
            rollback = ptr_dist(ckpt_head, head);
        count_sum = {1'b0, count} + fl_sum_t'(rollback) + fl_sum_t'(n_ret) - fl_sum_t'(n_grant);

        fl.freelist_0 = entry[head];
        fl.freelist_1 = grant_0 ? entry[head_p1] : entry[head];
        fl.pr_valid_0 = grant_0;
        fl.pr_valid_1 = grant_1;
        fl.fl_count   = count;
        fl.fl_busy    = (count < fl_cnt_t'(2));
    end

    // Returns are written at tail only; the entry array is never bypassed to the grant side.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                entry[i] <= phys_tag_t'(N_ARCH_REG + i);
            head       <= '0;
            tail       <= '0;
            ckpt_head  <= '0;
            ckpt_valid <= 1'b0;
            count      <= fl_cnt_t'(DEPTH);
        end else begin
            assert (count_sum <= fl_sum_t'(DEPTH));
            if (ret_0)
                entry[tail] <= fl.Told_in_0;
            if (ret_1)
                entry[ret_0 ? tail_p1 : tail] <= fl.Told_in_1;
            tail  <= tail_adv;
            count <= fl_cnt_t'(count_sum);

            if (fl.recovery_br) begin
                if (ckpt_valid)
                    head <= ckpt_head;
                ckpt_valid <= 1'b0;
            end else begin
                head <= head_adv;
                if (fl.fetch_PR_0 && fl.is_0_br) begin
                    ckpt_head  <= grant_0 ? head_p1 : head;
                    ckpt_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_freelist.sv
// Scoreboard bench for freelist: a queue-based model of free, retirable and
// speculative tags predicts each cycle's grants; a negedge monitor compares.
module tb_freelist;
    import freelist_pkg::*;

    typedef struct {
        bit v0;
        bit v1;
        int t0;
        int t1;
        int cnt;
        bit busy;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    freelist_if fl();

    freelist dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    always #5 clock = ~clock;

    exp_t exp_q[$];
    int   freeq[$];
    int   retirable[$];
    int   spec_q[$];
    bit   ckpt_v;
    int   total = 0;
    int   bad   = 0;

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle while the DUT's combinational outputs are stable.
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("pr_valid_0", int'(fl.pr_valid_0), int'(e.v0));
            checkOutput("pr_valid_1", int'(fl.pr_valid_1), int'(e.v1));
            checkOutput("fl_count", int'(fl.fl_count), e.cnt);
            checkOutput("fl_busy", int'(fl.fl_busy), int'(e.busy));
            if (e.v0) checkOutput("freelist_0", int'(fl.freelist_0), e.t0);
            if (e.v1) checkOutput("freelist_1", int'(fl.freelist_1), e.t1);
        end
    end

    task automatic modelReset();
        freeq.delete();
        retirable.delete();
        spec_q.delete();
        for (int i = 0; i < DEPTH; i++) freeq.push_back(N_ARCH_REG + i);
        for (int i = 0; i < ZERO_REG; i++) retirable.push_back(i);
        ckpt_v = 0;
    endtask

    task automatic dropTag(input int t);
        for (int i = 0; i < retirable.size(); i++) begin
            if (retirable[i] == t) begin
                retirable.delete(i);
                return;
            end
        end
    endtask

    task automatic driveIdle();
        fl.fetch_PR_0  = 0;
        fl.fetch_PR_1  = 0;
        fl.is_0_br     = 0;
        fl.recovery_br = 0;
        fl.rt_valid_0  = 0;
        fl.rt_valid_1  = 0;
        fl.Told_in_0   = '0;
        fl.Told_in_1   = '0;
    endtask

    task automatic applyStimulus(input bit f0, input bit f1, input bit br, input bit rec,
                                 input bit rv0, input bit rv1, input int t0, input int t1);
        exp_t e;
        int   free;
        int   tag0;
        int   tag1;
        bit   g0;
        bit   g1;
        fl.fetch_PR_0  = f0;
        fl.fetch_PR_1  = f1;
        fl.is_0_br     = br;
        fl.recovery_br = rec;
        fl.rt_valid_0  = rv0;
        fl.rt_valid_1  = rv1;
        fl.Told_in_0   = phys_tag_t'(t0);
        fl.Told_in_1   = phys_tag_t'(t1);

        free   = freeq.size();
        g0     = f0 && !rec && free >= 1;
        g1     = f1 && !rec && free >= (g0 ? 2 : 1);
        e.v0   = g0;
        e.v1   = g1;
        e.t0   = g0 ? freeq[0] : 0;
        e.t1   = g1 ? freeq[g0 ? 1 : 0] : 0;
        e.cnt  = free;
        e.busy = free < 2;
        exp_q.push_back(e);

        tag0 = 0;
        tag1 = 0;
        if (g0) tag0 = freeq.pop_front();
        if (g1) tag1 = freeq.pop_front();
        if (rec) begin
            if (ckpt_v) freeq = {spec_q, freeq};
            spec_q.delete();
            ckpt_v = 0;
        end else if (f0 && br) begin
            while (spec_q.size() > 0) retirable.push_back(spec_q.pop_front());
            if (g0) retirable.push_back(tag0);
            if (g1) spec_q.push_back(tag1);
            ckpt_v = 1;
        end else begin
            if (g0) begin
                if (ckpt_v) spec_q.push_back(tag0); else retirable.push_back(tag0);
            end
            if (g1) begin
                if (ckpt_v) spec_q.push_back(tag1); else retirable.push_back(tag1);
            end
        end
        if (rv0 && t0 != ZERO_REG) begin
            freeq.push_back(t0);
            dropTag(t0);
        end
        if (rv1 && t1 != ZERO_REG) begin
            freeq.push_back(t1);
            dropTag(t1);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic randomCycle(input int fetch_pct, input int ret_pct);
        bit f0, f1, br, rec, rv0, rv1;
        int t0, t1, budget, i0, i1;
        f0  = $urandom_range(0, 99) < fetch_pct;
        f1  = $urandom_range(0, 99) < fetch_pct;
        br  = f0 && ($urandom_range(0, 9) < 2);
        rec = ($urandom_range(0, 19) == 0);
        if (spec_q.size() >= DEPTH - 2) begin
            f0 = 0;
            f1 = 0;
        end
        rv0 = 0; rv1 = 0; t0 = 0; t1 = 0; i0 = -1;
        budget = DEPTH - freeq.size() - spec_q.size();
        if ($urandom_range(0, 99) < ret_pct) begin
            rv0 = 1;
            if ($urandom_range(0, 9) == 0 || retirable.size() == 0 || budget < 1) begin
                t0 = ZERO_REG;
            end else begin
                i0 = $urandom_range(0, retirable.size() - 1);
                t0 = retirable[i0];
                budget--;
            end
        end
        if ($urandom_range(0, 99) < ret_pct) begin
            rv1 = 1;
            i1 = (retirable.size() > 0) ? $urandom_range(0, retirable.size() - 1) : -1;
            if ($urandom_range(0, 9) == 0 || i1 < 0 || i1 == i0 || budget < 1)
                t1 = ZERO_REG;
            else
                t1 = retirable[i1];
        end
        applyStimulus(f0, f1, br, rec, rv0, rv1, t0, t1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        driveIdle();
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        modelReset();

        // Reset state, first dual grant, then drain to empty.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        // Return at empty: ZERO_REG is dropped, 5 is reissued next.
        applyStimulus(0, 0, 0, 0, 1, 1, 5, ZERO_REG);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);

        // Branch checkpoint at head=4, three younger grants, then recovery.
        driveIdle();
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        modelReset();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        // Recovery with retire and fetch in the same cycle.
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 1, 32, 3);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);

        // Steady-state single alloc/return so both pointers wrap.
        for (int i = 0; i < 40; i++) begin
            if (retirable.size() > 0 && freeq.size() + spec_q.size() < DEPTH)
                applyStimulus(1, 0, 0, 0, 1, 0, retirable[0], 0);
            else
                applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        end

        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 500; i++)
                randomCycle((p % 2 == 0) ? 80 : 25, (p % 2 == 0) ? 30 : 80);

        // Reset mid-operation with requests present: grants of that cycle are discarded.
        fl.fetch_PR_0 = 1;
        fl.fetch_PR_1 = 1;
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        driveIdle();
        modelReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) randomCycle(60, 60);

        driveIdle();
        @(posedge clock);
        #1;
        checkOutput("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
